// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types, memory-map constants and size helper for the data-side router
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_B  = 2'b00,
    SZ_H  = 2'b01,
    SZ_W  = 2'b10,
    SZ_RD = 2'b11
  } mem_size_t;

  typedef enum {R_IDLE, R_REQ, R_WAIT, R_RESP} router_state_t;

  // Current memory map: program/data RAM in the low 1 MiB, video RAM page, keyboard register
  localparam logic [31:0] MAP_RAM_BASE   = 32'h0000_0000;
  localparam logic [31:0] MAP_RAM_MASK   = 32'hFFF0_0000;
  localparam logic [31:0] MAP_VIDEO_BASE = 32'hF000_0000;
  localparam logic [31:0] MAP_VIDEO_MASK = 32'hFFFF_F000;
  localparam logic [31:0] MAP_KBD_BASE   = 32'hFFFF_FFFF;
  localparam logic [31:0] MAP_KBD_MASK   = 32'hFFFF_FFFF;

  // Allowed-size masks: bit k set means size code k is permitted
  localparam logic [3:0] SZ_OK_ALL       = 4'hF;
  localparam logic [3:0] SZ_OK_BYTE_ONLY = 4'h1;
  localparam logic [3:0] SZ_OK_READ_ONLY = 4'h8;

  function automatic logic size_allowed(input logic [3:0] ok_bits, input logic [1:0] size);
    return ok_bits[size];
  endfunction

endpackage

// File: rtl/mem_region_router_decoder.sv
// rtl/mem_region_router_decoder.sv - priority address decoder with per-region size legality
module region_decoder
  import mem_pkg::*;
#(
  parameter int                      N_REG     = 4,
  parameter int                      ADDR_W    = 32,
  parameter int                      IDX_W     = (N_REG > 1) ? $clog2(N_REG) : 1,
  parameter logic [N_REG*ADDR_W-1:0] REG_BASE  = '0,
  parameter logic [N_REG*ADDR_W-1:0] REG_MASK  = '0,
  parameter logic [N_REG*4-1:0]      REG_SZ_OK = {N_REG{4'hF}}
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        size,
  output logic              hit,
  output logic [IDX_W-1:0]  idx,
  output logic              legal
);

  logic [3:0] sz_bits;

  // Scan from the top index down so the lowest hitting region overwrites the rest
  always_comb begin
    hit     = 1'b0;
    idx     = '0;
    sz_bits = '0;
    for (int i = N_REG - 1; i >= 0; i--) begin
      if ((addr & REG_MASK[i*ADDR_W +: ADDR_W]) == REG_BASE[i*ADDR_W +: ADDR_W]) begin
        hit     = 1'b1;
        idx     = IDX_W'(i);
        sz_bits = REG_SZ_OK[i*4 +: 4];
      end
    end
    legal = hit && size_allowed(sz_bits, size);
  end

endmodule

// File: rtl/mem_region_router.sv
// rtl/mem_region_router.sv - CPU data port router to N targets with one outstanding access and timeout
module mem_region_router
  import mem_pkg::*;
#(
  parameter int                      N_REG     = 4,
  parameter int                      ADDR_W    = 32,
  parameter int                      DATA_W    = 32,
  parameter int                      TMO_CYC   = 255,
  parameter logic [N_REG*ADDR_W-1:0] REG_BASE  = '0,
  parameter logic [N_REG*ADDR_W-1:0] REG_MASK  = '0,
  parameter logic [N_REG*4-1:0]      REG_SZ_OK = {N_REG{4'hF}}
) (
  input  logic                    CLK_CPU,
  input  logic                    resetp,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [1:0]              req_size,
  input  logic [DATA_W-1:0]       req_wdata,
  output logic                    rsp_valid,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic                    rsp_err,
  output logic [N_REG-1:0]        tgt_req_valid,
  input  logic [N_REG-1:0]        tgt_req_ready,
  output logic [ADDR_W-1:0]       tgt_addr,
  output logic [1:0]              tgt_size,
  output logic [DATA_W-1:0]       tgt_wdata,
  input  logic [N_REG-1:0]        tgt_rsp_valid,
  input  logic [N_REG*DATA_W-1:0] tgt_rsp_rdata
);

  localparam int IDX_W = (N_REG > 1) ? $clog2(N_REG) : 1;
  localparam int CNT_W = $clog2(TMO_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TMO_CYC);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_CYC - 1);

  router_state_t     state, state_nx;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  dec_idx;
  logic              dec_hit, dec_legal;
  logic [CNT_W-1:0]  cnt;
  logic              sel_ready, sel_rsp, tmo_hit, done_ok;
  logic [DATA_W-1:0] sel_rdata;

  region_decoder #(
    .N_REG    (N_REG),
    .ADDR_W   (ADDR_W),
    .IDX_W    (IDX_W),
    .REG_BASE (REG_BASE),
    .REG_MASK (REG_MASK),
    .REG_SZ_OK(REG_SZ_OK)
  ) u_decoder (
    .addr (req_addr),
    .size (req_size),
    .hit  (dec_hit),
    .idx  (dec_idx),
    .legal(dec_legal)
  );

  // Only the latched target's handshake and data are ever looked at
  assign sel_ready = tgt_req_ready[idx_q];
  assign sel_rsp   = tgt_rsp_valid[idx_q];
  assign sel_rdata = tgt_rsp_rdata[idx_q*DATA_W +: DATA_W];
  assign tmo_hit   = (cnt == TMO_LAST);

  // State register
  always_ff @(posedge CLK_CPU) begin
    if (resetp) state <= R_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; a real response in the same cycle as the timeout wins
  always_comb begin
    state_nx = state;
    done_ok  = 1'b0;
    case (state)
      R_IDLE: begin
        if (req_valid) state_nx = (dec_hit && dec_legal) ? R_REQ : R_RESP;
      end
      R_REQ: begin
        if (sel_ready && sel_rsp) begin
          state_nx = R_RESP;
          done_ok  = 1'b1;
        end else if (tmo_hit) begin
          state_nx = R_RESP;
        end else if (sel_ready) begin
          state_nx = R_WAIT;
        end
      end
      R_WAIT: begin
        if (sel_rsp) begin
          state_nx = R_RESP;
          done_ok  = 1'b1;
        end else if (tmo_hit) begin
          state_nx = R_RESP;
        end
      end
      R_RESP:  state_nx = R_IDLE;
      default: state_nx = R_IDLE;
    endcase
  end

  // Handshake outputs decoded from the current state
  always_comb begin
    req_ready     = (state == R_IDLE);
    rsp_valid     = (state == R_RESP);
    tgt_req_valid = '0;
    if (state == R_REQ) tgt_req_valid[idx_q] = 1'b1;
  end

  // Request latch, saturating timeout counter and held response registers
  always_ff @(posedge CLK_CPU) begin
    if (resetp) begin
      tgt_addr  <= '0;
      tgt_size  <= '0;
      tgt_wdata <= '0;
      idx_q     <= '0;
      cnt       <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        R_IDLE: begin
          if (req_valid) begin
            tgt_addr  <= req_addr;
            tgt_size  <= req_size;
            tgt_wdata <= req_wdata;
            idx_q     <= dec_idx;
            cnt       <= '0;
            if (!(dec_hit && dec_legal)) begin
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end
          end
        end
        R_REQ, R_WAIT: begin
          if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
          if (state_nx == R_RESP) begin
            rsp_err   <= ~done_ok;
            rsp_rdata <= (done_ok && tgt_size == SZ_RD) ? sel_rdata : '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_region_router.sv
// tb/tb_mem_region_router.sv - scoreboard bench for mem_region_router with directed vectors
module tb_mem_region_router;
  import mem_pkg::*;

  localparam int N_REG  = 3;
  localparam int TMO    = 8;
  localparam logic [N_REG*32-1:0] BASE  = {MAP_KBD_BASE, MAP_VIDEO_BASE, MAP_RAM_BASE};
  localparam logic [N_REG*32-1:0] MASK  = {MAP_KBD_MASK, MAP_VIDEO_MASK, MAP_RAM_MASK};
  localparam logic [N_REG*4-1:0]  SZ_OK = {SZ_OK_READ_ONLY, SZ_OK_BYTE_ONLY, SZ_OK_ALL};

  logic                CLK_CPU = 1'b0;
  logic                resetp;
  logic                req_valid;
  logic                req_ready;
  logic [31:0]         req_addr;
  logic [1:0]          req_size;
  logic [31:0]         req_wdata;
  logic                rsp_valid;
  logic [31:0]         rsp_rdata;
  logic                rsp_err;
  logic [N_REG-1:0]    tgt_req_valid;
  logic [N_REG-1:0]    tgt_req_ready;
  logic [31:0]         tgt_addr;
  logic [1:0]          tgt_size;
  logic [31:0]         tgt_wdata;
  logic [N_REG-1:0]    tgt_rsp_valid;
  logic [N_REG*32-1:0] tgt_rsp_rdata;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  mem_region_router #(
    .N_REG(N_REG), .ADDR_W(32), .DATA_W(32), .TMO_CYC(TMO),
    .REG_BASE(BASE), .REG_MASK(MASK), .REG_SZ_OK(SZ_OK)
  ) dut (
    .CLK_CPU(CLK_CPU), .resetp(resetp),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_size(req_size), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .tgt_req_valid(tgt_req_valid), .tgt_req_ready(tgt_req_ready),
    .tgt_addr(tgt_addr), .tgt_size(tgt_size), .tgt_wdata(tgt_wdata),
    .tgt_rsp_valid(tgt_rsp_valid), .tgt_rsp_rdata(tgt_rsp_rdata)
  );

  always #5 CLK_CPU = ~CLK_CPU;

  always @(posedge CLK_CPU) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every response pulse is matched against the oldest expectation
  always @(negedge CLK_CPU) begin
    if (rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
        check("rsp_latency", cyc - e.acc, e.lat);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK_CPU);
      #1;
    end
  endtask

  // Present one request; called and returns 1 time unit after a rising edge
  task automatic issue(input logic [31:0] a, input logic [1:0] s, input logic [31:0] w,
                       input logic [31:0] e_rdata, input logic e_err, input int e_lat);
    int   n = 0;
    exp_t e;
    while (req_ready !== 1'b1 && n < 50) begin
      step(1);
      n++;
    end
    if (n >= 50) check("req_ready_timeout", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_addr  = a;
    req_size  = s;
    req_wdata = w;
    step(1);
    req_valid = 1'b0;
    e.rdata = e_rdata;
    e.err   = e_err;
    e.acc   = cyc;
    e.lat   = e_lat;
    exp_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetp        = 1'b1;
    req_valid     = 1'b0;
    req_addr      = '0;
    req_size      = '0;
    req_wdata     = '0;
    tgt_req_ready = '0;
    tgt_rsp_valid = '0;
    tgt_rsp_rdata = '0;
    step(2);
    resetp = 1'b0;
    @(negedge CLK_CPU);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("rst_tgt_req_valid", {29'd0, tgt_req_valid}, 32'd0);
    check("rst_tgt_addr", tgt_addr, 32'd0);
    check("rst_tgt_size", {30'd0, tgt_size}, 32'd0);
    check("rst_tgt_wdata", tgt_wdata, 32'd0);
    @(posedge CLK_CPU);
    #1;

    // Read from R0; R1 raises a stray completion that must be ignored
    issue(32'h0000_0040, SZ_RD, 32'h0, 32'hDEAD_BEEF, 1'b0, 2);
    tgt_req_ready = 3'b001;
    tgt_rsp_valid = 3'b010;
    tgt_rsp_rdata[32 +: 32] = 32'h5555_5555;
    @(negedge CLK_CPU);
    check("t1_tgt_req_valid", {29'd0, tgt_req_valid}, 32'h1);
    check("t1_tgt_addr", tgt_addr, 32'h0000_0040);
    check("t1_tgt_size", {30'd0, tgt_size}, 32'h3);
    @(posedge CLK_CPU);
    #1;
    tgt_req_ready = 3'b000;
    tgt_rsp_valid = 3'b001;
    tgt_rsp_rdata[0 +: 32] = 32'hDEAD_BEEF;
    @(negedge CLK_CPU);
    check("t1_wait_no_req", {29'd0, tgt_req_valid}, 32'h0);
    step(1);
    tgt_rsp_valid = 3'b000;
    step(1);

    // Word write to the byte-only video region is rejected without touching the target
    issue(32'hF000_0010, SZ_W, 32'h1234_5678, 32'h0, 1'b1, 0);
    @(negedge CLK_CPU);
    check("t2_no_tgt_req", {29'd0, tgt_req_valid}, 32'h0);
    step(1);

    // Byte write to R1 with ready and response tied high
    tgt_req_ready = 3'b010;
    tgt_rsp_valid = 3'b010;
    tgt_rsp_rdata[32 +: 32] = 32'h1111_1111;
    issue(32'hF000_0010, SZ_B, 32'h0000_00A5, 32'h0, 1'b0, 1);
    @(negedge CLK_CPU);
    check("t3_tgt_req_valid", {29'd0, tgt_req_valid}, 32'h2);
    check("t3_tgt_wdata", tgt_wdata, 32'h0000_00A5);
    check("t3_tgt_size", {30'd0, tgt_size}, 32'h0);
    step(1);
    tgt_req_ready = 3'b000;
    tgt_rsp_valid = 3'b000;
    step(1);

    // Unmapped read
    issue(32'h1234_5678, SZ_RD, 32'h0, 32'h0, 1'b1, 0);
    step(1);

    // Keyboard read that never completes: timeout, then a late completion is ignored
    tgt_req_ready = 3'b100;
    tgt_rsp_rdata[64 +: 32] = 32'h2222_2222;
    issue(32'hFFFF_FFFF, SZ_RD, 32'h0, 32'h0, 1'b1, TMO);
    @(negedge CLK_CPU);
    check("t5_tgt_req_valid", {29'd0, tgt_req_valid}, 32'h4);
    step(TMO);
    tgt_rsp_valid = 3'b100;
    step(3);
    tgt_rsp_valid = 3'b000;
    tgt_req_ready = 3'b000;
    @(negedge CLK_CPU);
    check("t5_err_held", {31'd0, rsp_err}, 32'd1);
    check("t5_rdata_held", rsp_rdata, 32'd0);
    check("t5_req_ready", {31'd0, req_ready}, 32'd1);
    step(1);

    // Reset while waiting on R0, then a normal read
    tgt_req_ready = 3'b001;
    issue(32'h0000_0080, SZ_RD, 32'h0, 32'h0, 1'b0, 0);
    void'(exp_q.pop_back());
    step(1);
    tgt_req_ready = 3'b000;
    resetp = 1'b1;
    step(1);
    resetp = 1'b0;
    @(negedge CLK_CPU);
    check("t6_req_ready", {31'd0, req_ready}, 32'd1);
    check("t6_rsp_err_cleared", {31'd0, rsp_err}, 32'd0);
    check("t6_no_tgt_req", {29'd0, tgt_req_valid}, 32'h0);
    step(2);
    tgt_req_ready = 3'b001;
    tgt_rsp_valid = 3'b001;
    tgt_rsp_rdata[0 +: 32] = 32'hCAFE_F00D;
    issue(32'h0000_0080, SZ_RD, 32'h0, 32'hCAFE_F00D, 1'b0, 1);
    step(1);
    tgt_req_ready = 3'b000;
    tgt_rsp_valid = 3'b000;

    begin
      int n = 0;
      while (exp_q.size() != 0 && n < 50) begin
        step(1);
        n++;
      end
    end
    step(2);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
